pe_array_feeder: RTL and testbench

- Sequencer that drives the 32x32 PE array's input side: current-block pixels, reference-window rows, and the PE control signals.
- Accepts current-block and reference streams from the on-chip line buffers over valid/ready. It loads the current block, pre-fills the reference window, then steps the window one row per beat.
- Emits a candidate strobe with the vertical offset so the downstream SAD tree knows when the array's abs_outs is meaningful.

---
 rtl/pe_array_feeder_pkg.sv | 25 ++
 rtl/pe_array_feeder_if.sv | 22 ++
 rtl/pe_array_feeder_cand_delay.sv | 25 ++
 rtl/pe_array_feeder.sv | 148 ++++++++++++++
 tb/tb_pe_array_feeder.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_array_feeder_pkg.sv
// Shared constants, encodings and types for the PE array feeder.
// Pixel geometry, ref shift encodings, FSM states, candidate tag.
package me_pkg;
    localparam int PIXEL = 8;
    localparam int X = 32;
    localparam int Y = 32;
    localparam int ROW_W = X * PIXEL;
    localparam int CUR_W = 2 * ROW_W;
    localparam int REF_W = 8 * ROW_W;
    localparam int CUR_BEATS = Y / 2;
    localparam int REF_BEATS = Y / 8;

    localparam logic [1:0] REF_HOLD   = 2'd0;
    localparam logic [1:0] REF_SHIFT1 = 2'd1;
    localparam logic [1:0] REF_SHIFT8 = 2'd2;

    typedef enum logic [2:0] {
        IDLE, LOAD_CUR, FILL_REF, SEARCH, DRAIN, DONE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] row;
    } cand_t;
endpackage

// File: rtl/pe_array_feeder_if.sv
// Current-block and reference-window streams from the line buffers.
// Both use valid/ready; the feeder is the slave side.
interface pe_array_feeder_if;
    import me_pkg::*;

    logic             cur_valid;
    logic             cur_ready;
    logic [CUR_W-1:0] cur_data;
    logic             ref_valid;
    logic             ref_ready;
    logic [REF_W-1:0] ref_data;

    modport master (
        output cur_valid, cur_data, ref_valid, ref_data,
        input  cur_ready, ref_ready
    );

    modport slave (
        input  cur_valid, cur_data, ref_valid, ref_data,
        output cur_ready, ref_ready
    );
endinterface

// File: rtl/pe_array_feeder_cand_delay.sv
// Delay line aligning candidate tags with the array's abs_outs.
// DEPTH stages of {valid, row}; output is the oldest stage.
module cand_delay
    import me_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  cand_t i_cand,
    output cand_t o_cand
);
    cand_t r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_cand;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_cand = r_pipe[DEPTH-1];
endmodule

// File: rtl/pe_array_feeder.sv
// Sequencer feeding current pixels and reference rows into the PE array.
// Loads the block, pre-fills 8-row window, then slides one row per beat.
module pe_array_feeder
    import me_pkg::*;
#(
    parameter int SR_ROWS = 32,
    parameter int ABS_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cb_sel,
    input  logic [1:0]       abs_sel,
    output logic             busy,
    output logic             done,
    pe_array_feeder_if.slave strm,
    output logic [CUR_W-1:0] current_64pixels,
    output logic             in_curr_enable,
    output logic             CB_select,
    output logic [1:0]       abs_Control,
    output logic [REF_W-1:0] ref_8R_32,
    output logic             change_ref,
    output logic [1:0]       ref_input_Control,
    output logic             cand_valid,
    output logic [7:0]       cand_row
);
    localparam logic [7:0] LAST_CUR  = 8'(CUR_BEATS - 1);
    localparam logic [7:0] LAST_FILL = 8'(REF_BEATS - 1);
    localparam logic [7:0] LAST_SR   = 8'((SR_ROWS > 0) ? SR_ROWS - 1 : 0);
    localparam logic [7:0] DRAIN_END = 8'(ABS_LAT);

    state_t           r_state, w_next;
    logic [7:0]       r_cnt;
    logic             w_cur_hs, w_ref_hs;
    logic [CUR_W-1:0] r_cur;
    logic [REF_W-1:0] r_ref;
    logic             r_en, r_chg, r_cb;
    logic [1:0]       r_abs, r_ric;
    cand_t            w_issue, r_issue, w_cand;

    assign w_cur_hs = strm.cur_valid & strm.cur_ready;
    assign w_ref_hs = strm.ref_valid & strm.ref_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (start) w_next = LOAD_CUR;
            LOAD_CUR: if (w_cur_hs && r_cnt == LAST_CUR) w_next = FILL_REF;
            FILL_REF: if (w_ref_hs && r_cnt == LAST_FILL)
                          w_next = (SR_ROWS == 0) ? DRAIN : SEARCH;
            SEARCH:   if (w_ref_hs && r_cnt == LAST_SR) w_next = DRAIN;
            DRAIN:    if (r_cnt == DRAIN_END) w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        strm.cur_ready = 1'b0;
        strm.ref_ready = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        unique case (r_state)
            LOAD_CUR: begin
                strm.cur_ready = 1'b1;
                busy           = 1'b1;
            end
            FILL_REF, SEARCH: begin
                strm.ref_ready = 1'b1;
                busy           = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // One counter serves every phase; it restarts on each state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_next != r_state)
            r_cnt <= '0;
        else if (w_cur_hs || w_ref_hs || r_state == DRAIN)
            r_cnt <= r_cnt + 8'd1;
    end

    always_comb begin
        w_issue.valid = w_ref_hs &&
            (r_state == SEARCH ||
             (r_state == FILL_REF && r_cnt == LAST_FILL));
        w_issue.row = (r_state == SEARCH) ? r_cnt + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur   <= '0;
            r_ref   <= '0;
            r_en    <= 1'b0;
            r_chg   <= 1'b0;
            r_ric   <= REF_HOLD;
            r_cb    <= 1'b0;
            r_abs   <= '0;
            r_issue <= '0;
        end else begin
            r_en    <= w_cur_hs;
            r_chg   <= w_ref_hs;
            r_issue <= w_issue;
            if (r_state == IDLE && start) begin
                r_cb  <= cb_sel;
                r_abs <= abs_sel;
            end
            if (w_cur_hs) r_cur <= strm.cur_data;
            if (!w_ref_hs) begin
                r_ric <= REF_HOLD;
            end else if (r_state == FILL_REF) begin
                r_ric <= REF_SHIFT8;
                r_ref <= strm.ref_data;
            end else begin
                // A slide brings in one row; the rest of the window stays put.
                r_ric <= REF_SHIFT1;
                r_ref[ROW_W-1:0] <= strm.ref_data[ROW_W-1:0];
            end
        end
    end

    cand_delay #(.DEPTH(ABS_LAT)) u_cand_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_cand (r_issue),
        .o_cand (w_cand)
    );

    assign current_64pixels  = r_cur;
    assign in_curr_enable    = r_en;
    assign CB_select         = r_cb;
    assign abs_Control       = r_abs;
    assign ref_8R_32         = r_ref;
    assign change_ref        = r_chg;
    assign ref_input_Control = r_ric;
    assign cand_valid        = w_cand.valid;
    assign cand_row          = w_cand.row;
endmodule

// File: tb/tb_pe_array_feeder.sv
// Randomised bench for pe_array_feeder against a beat-counting model.
// Second instance covers the zero-search, three-cycle-latency corner.
module tb_pe_array_feeder;
    import me_pkg::*;

    localparam int SR_A = 32, LAT_A = 1;
    localparam int SR_B = 0,  LAT_B = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pe_array_feeder_if a_if ();
    pe_array_feeder_if b_if ();

    logic a_start, a_cb, a_busy, a_done, a_en, a_cbs, a_chg, a_cv;
    logic [1:0] a_abs, a_absc, a_ric;
    logic [CUR_W-1:0] a_cur;
    logic [REF_W-1:0] a_ref;
    logic [7:0] a_crow;

    logic b_start, b_busy, b_done, b_en, b_cbs, b_chg, b_cv;
    logic [1:0] b_absc, b_ric;
    logic [CUR_W-1:0] b_cur;
    logic [REF_W-1:0] b_ref;
    logic [7:0] b_crow;

    pe_array_feeder #(.SR_ROWS(SR_A), .ABS_LAT(LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .cb_sel(a_cb),
        .abs_sel(a_abs), .busy(a_busy), .done(a_done), .strm(a_if),
        .current_64pixels(a_cur), .in_curr_enable(a_en),
        .CB_select(a_cbs), .abs_Control(a_absc), .ref_8R_32(a_ref),
        .change_ref(a_chg), .ref_input_Control(a_ric),
        .cand_valid(a_cv), .cand_row(a_crow));

    pe_array_feeder #(.SR_ROWS(SR_B), .ABS_LAT(LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .cb_sel(1'b1),
        .abs_sel(2'd2), .busy(b_busy), .done(b_done), .strm(b_if),
        .current_64pixels(b_cur), .in_curr_enable(b_en),
        .CB_select(b_cbs), .abs_Control(b_absc), .ref_8R_32(b_ref),
        .change_ref(b_chg), .ref_input_Control(b_ric),
        .cand_valid(b_cv), .cand_row(b_crow));

    int n_chk = 0, n_err = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [REF_W-1:0] act,
                         input logic [REF_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got_lo=%0h want_lo=%0h",
                     nm, cyc, act[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [REF_W-1:0] rnd_wide();
        logic [REF_W-1:0] r;
        for (int i = 0; i < REF_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [CUR_W-1:0] pat_beat(input int k);
        logic [CUR_W-1:0] d;
        for (int p = 0; p < X; p++) begin
            d[p*PIXEL +: PIXEL]         = 8'(2 * k);
            d[ROW_W + p*PIXEL +: PIXEL] = 8'(2 * k + 1);
        end
        return d;
    endfunction

    // Model: block progress is just "how many beats of each stream so far".
    logic m_active;
    int m_nc, m_nr, done_at;
    logic e_done, e_en, e_chg, e_cb, e_cv;
    logic [1:0] e_abs, e_ric;
    logic [7:0] e_crow;
    logic [CUR_W-1:0] e_cur;
    logic [REF_W-1:0] e_ref;
    int q_due[$];
    int q_row[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_nc = 0; m_nr = 0; done_at = -1;
            e_done = 0; e_en = 0; e_chg = 0; e_cb = 0; e_cv = 0;
            e_abs = 0; e_ric = 0; e_crow = 0; e_cur = '0; e_ref = '0;
            q_due.delete(); q_row.delete();
        end else begin
            logic acc, ch, rh;
            cyc++;
            acc = !m_active && !e_done && a_start;
            ch  = m_active && m_nc < CUR_BEATS && a_if.cur_valid;
            rh  = m_active && m_nc == CUR_BEATS &&
                  m_nr < REF_BEATS + SR_A && a_if.ref_valid;
            e_en = ch; e_chg = rh; e_ric = 0; e_done = 0; e_cv = 0;
            if (acc) begin
                m_active = 1; m_nc = 0; m_nr = 0;
                e_cb = a_cb; e_abs = a_abs;
            end
            if (ch) begin
                e_cur = a_if.cur_data;
                m_nc++;
            end
            if (rh) begin
                if (m_nr < REF_BEATS) begin
                    e_ref = a_if.ref_data; e_ric = 2;
                end else begin
                    e_ref[ROW_W-1:0] = a_if.ref_data[ROW_W-1:0]; e_ric = 1;
                end
                m_nr++;
                if (m_nr >= REF_BEATS) begin
                    q_due.push_back(cyc + LAT_A);
                    q_row.push_back(m_nr - REF_BEATS);
                end
                if (m_nr == REF_BEATS + SR_A) done_at = cyc + LAT_A + 1;
            end
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                e_cv = 1; e_crow = 8'(q_row[0]);
                void'(q_due.pop_front()); void'(q_row.pop_front());
            end
            if (cyc == done_at) begin
                m_active = 0; e_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 64'(a_busy), 64'(m_active));
            chk("done", 64'(a_done), 64'(e_done));
            chk("cur_ready", 64'(a_if.cur_ready),
                64'(m_active && m_nc < CUR_BEATS));
            chk("ref_ready", 64'(a_if.ref_ready),
                64'(m_active && m_nc == CUR_BEATS && m_nr < REF_BEATS + SR_A));
            chk("in_curr_enable", 64'(a_en), 64'(e_en));
            chk_w("current_64pixels", REF_W'(a_cur), REF_W'(e_cur));
            chk("change_ref", 64'(a_chg), 64'(e_chg));
            chk("ref_input_Control", 64'(a_ric), 64'(e_ric));
            chk_w("ref_8R_32", a_ref, e_ref);
            chk("CB_select", 64'(a_cbs), 64'(e_cb));
            chk("abs_Control", 64'(a_absc), 64'(e_abs));
            chk("cand_valid", 64'(a_cv), 64'(e_cv));
            if (e_cv) chk("cand_row", 64'(a_crow), 64'(e_crow));
        end
    end

    int mon_en = 0, mon_last_en = 0, mon_c8 = 0, mon_c1 = 0;
    int mon_cand = 0, mon_bad = 0, mon_next = 0, mon_last_cand = 0;
    int mon_last_row = -1, mon_done = 0, mon_done_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_en) begin mon_en++; mon_last_en = cyc; end
            if (a_chg && a_ric == 2) mon_c8++;
            if (a_chg && a_ric == 1) mon_c1++;
            if (a_cv) begin
                mon_cand++;
                if (a_crow != 0 && int'(a_crow) != mon_next) mon_bad++;
                mon_next = int'(a_crow) + 1;
                mon_last_cand = cyc;
                mon_last_row = int'(a_crow);
            end
            if (a_done) begin mon_done++; mon_done_cyc = cyc; end
        end
    end

    int mode = 0, pat_on = 0, pat_k = 0;
    int stall_left = 0, stalled = 0, stall_seen = 0;
    logic tog = 1'b0;
    int s0, sn_en, sn_c8, sn_c1, sn_cand, sn_bad, sn_done;

    task automatic drive_data();
        logic [REF_W-1:0] t;
        t = rnd_wide();
        a_if.cur_data = pat_on ? pat_beat(pat_k % CUR_BEATS) : t[CUR_W-1:0];
        a_if.ref_data = rnd_wide();
    endtask

    task automatic cycle_a();
        @(negedge clk);
        if (a_if.cur_valid && a_if.cur_ready) pat_k++;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        case (mode)
            1: begin
                tog = ~tog;
                a_if.cur_valid = tog;
                if (!stalled && mon_cand - sn_cand >= 15) begin
                    stall_left = 5; stalled = 1;
                end
                if (stall_left > 0) begin
                    a_if.ref_valid = 1'b0; stall_left--; stall_seen++;
                end else a_if.ref_valid = 1'b1;
            end
            2: begin
                a_if.cur_valid = 1'($urandom_range(0, 1));
                a_if.ref_valid = 1'($urandom_range(0, 1));
                if (a_busy && $urandom_range(0, 7) == 0) begin
                    a_start = 1'b1; a_cb = 1'($urandom); a_abs = 2'($urandom);
                end
            end
            default: begin
                a_if.cur_valid = 1'b1; a_if.ref_valid = 1'b1;
            end
        endcase
        drive_data();
    endtask

    task automatic begin_block(input logic cb, input logic [1:0] ab);
        @(posedge clk);
        #1;
        a_start = 1'b1; a_cb = cb; a_abs = ab;
        pat_k = 0; stalled = 0; stall_left = 0;
        drive_data();
        s0 = cyc;
        sn_en = mon_en; sn_c8 = mon_c8; sn_c1 = mon_c1;
        sn_cand = mon_cand; sn_bad = mon_bad; sn_done = mon_done;
    endtask

    task automatic wait_done(input int poke_done);
        int n;
        n = 0;
        while (mon_done == sn_done && n < 400) begin
            cycle_a();
            if (poke_done != 0 && a_done) begin
                a_start = 1'b1; a_cb = ~a_cbs;
            end
            n++;
        end
        if (mon_done == sn_done) chk("done_timeout", 64'(n), 64'd0);
    endtask

    task automatic check_counts(input int full_timing);
        chk("en_pulses", 64'(mon_en - sn_en), 64'd16);
        chk("shift8_pulses", 64'(mon_c8 - sn_c8), 64'd4);
        chk("shift1_pulses", 64'(mon_c1 - sn_c1), 64'd32);
        chk("cand_count", 64'(mon_cand - sn_cand), 64'd33);
        chk("cand_seq_bad", 64'(mon_bad - sn_bad), 64'd0);
        chk("last_cand_row", 64'(mon_last_row), 64'd32);
        chk("done_count", 64'(mon_done - sn_done), 64'd1);
        chk("done_after_cand", 64'(mon_done_cyc - mon_last_cand), 64'd1);
        if (full_timing != 0) begin
            chk("last_en_cycle", 64'(mon_last_en - s0), 64'd17);
            chk("done_cycle", 64'(mon_done_cyc - s0), 64'd55);
        end
    endtask

    initial begin
        logic cb0;
        int n, nc8, t_c8, t_cv, t_d, bcv, bdn;
        logic [7:0] brow;
        a_start = 0; a_cb = 0; a_abs = 0; b_start = 0;
        a_if.cur_valid = 0; a_if.ref_valid = 0;
        a_if.cur_data = '0; a_if.ref_data = '0;
        b_if.cur_valid = 1; b_if.ref_valid = 1;
        b_if.cur_data = '1; b_if.ref_data = rnd_wide();

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_cand_row", 64'(a_crow), 64'd0);
        chk("rst_ric", 64'(a_ric), 64'd0);
        chk("rst_cb", 64'(b_cbs), 64'd0);
        #2 rst_n = 1'b1;

        mode = 0; pat_on = 0;
        begin_block(1'b0, 2'd0);
        wait_done(0);
        check_counts(1);

        pat_on = 1;
        begin_block(1'b1, 2'd3);
        repeat (10) cycle_a();
        chk("cb_mid", 64'(a_cbs), 64'd1);
        chk("abs_mid", 64'(a_absc), 64'd3);
        chk_w("beat9_pixels", REF_W'(a_cur), REF_W'(pat_beat(8)));
        wait_done(0);
        check_counts(1);
        pat_on = 0;

        mode = 1;
        begin_block(1'b0, 2'd1);
        wait_done(0);
        check_counts(0);
        chk("stall_cycles", 64'(stall_seen), 64'd5);

        mode = 2;
        cb0 = 1'($urandom);
        begin_block(cb0, 2'd2);
        wait_done(1);
        repeat (3) cycle_a();
        chk("no_restart_busy", 64'(a_busy), 64'd0);
        chk("cb_unchanged", 64'(a_cbs), 64'(cb0));
        check_counts(0);

        mode = 0;
        begin_block(1'b1, 2'd1);
        n = 0;
        while (!(mon_last_row == 10 && mon_cand > sn_cand) && n < 200) begin
            cycle_a(); n++;
        end
        chk("reach_row10", 64'(mon_last_row), 64'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(a_busy), 64'd0);
        chk("arst_chg", 64'(a_chg), 64'd0);
        chk("arst_ric", 64'(a_ric), 64'd0);
        chk("arst_cv", 64'(a_cv), 64'd0);
        chk("arst_ref_ready", 64'(a_if.ref_ready), 64'd0);
        chk("arst_cb", 64'(a_cbs), 64'd0);
        chk_w("arst_ref", a_ref, '0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) cycle_a();
        chk("no_done_after_reset", 64'(mon_done - sn_done), 64'd0);
        begin_block(1'b0, 2'd0);
        wait_done(0);
        check_counts(1);

        @(posedge clk);
        #1 b_start = 1'b1;
        @(negedge clk);
        nc8 = 0; t_c8 = -1; t_cv = -1; t_d = -1; bcv = 0; bdn = 0; brow = 8'hff;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_chg && b_ric == 2) begin
                nc8++;
                if (nc8 == 4) t_c8 = i;
            end
            if (b_cv) begin bcv++; t_cv = i; brow = b_crow; end
            if (b_done) begin bdn++; t_d = i; end
        end
        chk("b_fill4_cycle", 64'(t_c8), 64'd21);
        chk("b_cand_cycle", 64'(t_cv), 64'd24);
        chk("b_cand_row", 64'(brow), 64'd0);
        chk("b_cand_count", 64'(bcv), 64'd1);
        chk("b_done_cycle", 64'(t_d), 64'd25);
        chk("b_done_count", 64'(bdn), 64'd1);
        chk("b_cb", 64'(b_cbs), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
